stim_vote_ctrl: RTL and testbench
=================================

// Module: stim_vote_ctrl
// PURPOSE
//  Closed-loop stimulation controller; successor of the combinational majority-gate
//  controller. Collects one sample each of line-length (LL), power-spectrum (PS) and
//  nonlinear-energy (NE), compares each against a programmable signed threshold and
//  majority-votes the set. It fires a fixed-length stimulation pulse only after
//  HOLD_CNT consecutive positive votes, then enforces a refractory period.
//  Sits between the feature extractors and the stimulator driver.
// PARAMETERS
//  LL_WIDTH    25  LL sample/threshold width (signed)
//  MUL_WIDTH   40  PS/NE sample/threshold width (signed)
//  VOTE_MIN    2   positive votes (of 3) needed for a positive set; legal 1..3
//  HOLD_CNT    4   consecutive positive sets before stimulation; legal >=1
//  STIM_LEN    16  stimulation high time in clk cycles; legal >=1
//  REFRACT_LEN 64  refractory time in clk cycles; 0 = none
//  CNT_WIDTH   16  width of internal duration counters
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          asynchronous, active-high reset
//  en             in   1          controller enable
//  din_ll         in   LL_WIDTH   LL sample, signed
//  din_ps         in   MUL_WIDTH  PS sample, signed
//  din_ne         in   MUL_WIDTH  NE sample, signed
//  data_ready_ll  in   1          LL sample strobe, 1-cycle
//  data_ready_ps  in   1          PS sample strobe, 1-cycle
//  data_ready_ne  in   1          NE sample strobe, 1-cycle
//  th_ll          in   LL_WIDTH   LL threshold, signed, static while en=1
//  th_ps/th_ne    in   MUL_WIDTH  PS/NE thresholds, signed, static while en=1
//  clr_overrun    in   1          clears overrun
//  vote_valid     out  1          1-cycle pulse: a set was evaluated
//  vote_count     out  2          positive votes of last set (0..3)
//  stimulation    out  1          stimulator drive
//  state          out  2          FSM state: 0 IDLE, 1 ARMED, 2 STIM, 3 REFRACT
//  overrun        out  1          sticky: feature re-strobed before set completed
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, pending flags and counters cleared.
//  Collect: a strobe captures its sample and sets the feature's pending flag. The
//   set completes in the cycle n in which the last missing strobe is high
//   (simultaneous strobes allowed). All pending flags are cleared at end of cycle n.
//  Per-feature hit = (sample >= threshold), full-width signed compare.
//  vote_count = number of hits; vote_valid is high in cycle n+1 (1-cycle latency).
//  A strobe for an already-pending feature overwrites the sample and sets overrun.
//  Overrun stays set until clr_overrun. If clr_overrun and a new overrun occur in the
//   same cycle, the set wins.
//  positive = vote_valid && vote_count >= VOTE_MIN. hits = consecutive-positive counter.
//  IDLE: on positive, hits=1. Go to STIM if HOLD_CNT==1, else to ARMED.
//  ARMED: on positive, hits++; go to STIM when hits reaches HOLD_CNT.
//   On a negative set, hits=0 and go to IDLE.
//  STIM: stimulation=1 for exactly STIM_LEN cycles, starting the cycle after the entry
//   decision. Sets are still evaluated (vote_* update) but do not affect the FSM.
//  REFRACT: lasts REFRACT_LEN cycles, then go to IDLE with hits=0. If REFRACT_LEN=0,
//   STIM goes directly to IDLE. Votes are ignored.
//  en=0: next edge forces IDLE, stimulation=0, hits=0, pending flags cleared,
//   strobes ignored. Rising en starts a fresh set. Async rst mid-pulse drops
//   stimulation immediately.
// CONFIGURATION
//  STIM_VOTE_MASK_EN defined: adds input feat_mask[2:0] ({ne,ps,ll}; 1 = excluded).
//   A masked feature never votes and is not awaited for set completion.
//   All three masked: no sets complete.
//   Undefined: port absent; all three features are always awaited and voted.
// TESTING
//  All three strobes together, samples 1500/1500/0, th=1000 -> vote_valid next
//   cycle, vote_count=2, FSM goes to ARMED.
//  4 consecutive positive sets (HOLD_CNT=4) -> stimulation high exactly 16 cycles,
//   then state=3 for 64 cycles, then IDLE.
//  3 positive sets then a set with vote_count=1 -> IDLE, no stimulation. The next
//   positive set restarts hits at 1.
//  LL strobed twice before PS/NE arrive -> overrun=1, second LL value used.
//   clr_overrun -> 0.
//  Negative sample -1 vs threshold -2 -> hit. Value 2^24-1 vs threshold -2^24 -> hit
//   (signed compare).
//  rst asserted mid-STIM -> stimulation 0 immediately. en dropped in ARMED -> IDLE
//   next edge, in-flight pending set discarded.

Source files
------------

// File: rtl/stim_vote_ctrl.sv
// Closed-loop stimulation controller: 2-of-3 style feature vote, hold-off counter, fixed
// stimulation pulse and refractory period. Optional macro STIM_VOTE_MASK_EN adds feat_mask.
module stim_vote_ctrl #(
  parameter int LL_WIDTH    = 25,
  parameter int MUL_WIDTH   = 40,
  parameter int VOTE_MIN    = 2,
  parameter int HOLD_CNT    = 4,
  parameter int STIM_LEN    = 16,
  parameter int REFRACT_LEN = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [LL_WIDTH-1:0]  din_ll,
  input  logic signed [MUL_WIDTH-1:0] din_ps,
  input  logic signed [MUL_WIDTH-1:0] din_ne,
  input  logic                        data_ready_ll,
  input  logic                        data_ready_ps,
  input  logic                        data_ready_ne,
  input  logic signed [LL_WIDTH-1:0]  th_ll,
  input  logic signed [MUL_WIDTH-1:0] th_ps,
  input  logic signed [MUL_WIDTH-1:0] th_ne,
  input  logic                        clr_overrun,
  output logic                        vote_valid,
  output logic [1:0]                  vote_count,
  output logic                        stimulation,
  output logic [1:0]                  state,
  output logic                        overrun
`ifdef STIM_VOTE_MASK_EN
  ,
  input  logic [2:0]                  feat_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STIM    = 2'd2,
    REFRACT = 2'd3
  } state_t;

  localparam logic [1:0]           VOTE_MIN_V = 2'(VOTE_MIN);
  localparam logic [CNT_WIDTH-1:0] HOLD_V     = CNT_WIDTH'(HOLD_CNT);
  localparam logic [CNT_WIDTH-1:0] STIM_LAST  = CNT_WIDTH'(STIM_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] REFR_LAST  =
    CNT_WIDTH'((REFRACT_LEN == 0) ? 0 : REFRACT_LEN - 1);

  // Bit order everywhere is {ne, ps, ll}.
  logic [2:0] req;
`ifdef STIM_VOTE_MASK_EN
  assign req = ~feat_mask;
`else
  assign req = 3'b111;
`endif

  logic [2:0]                  strb, pend_q, have, hit;
  logic                        complete;
  logic signed [LL_WIDTH-1:0]  smp_ll, val_ll;
  logic signed [MUL_WIDTH-1:0] smp_ps, smp_ne, val_ps, val_ne;

  assign strb = {data_ready_ne, data_ready_ps, data_ready_ll} & req & {3{en}};
  assign have = pend_q | strb;
  // A set needs at least one live strobe this cycle so that an all-masked setup never fires.
  assign complete = (|req) && (|strb) && ((have | ~req) == 3'b111);

  // The completing strobe's sample is compared directly so the vote lands one cycle later.
  assign val_ll = strb[0] ? din_ll : smp_ll;
  assign val_ps = strb[1] ? din_ps : smp_ps;
  assign val_ne = strb[2] ? din_ne : smp_ne;
  assign hit    = {val_ne >= th_ne, val_ps >= th_ps, val_ll >= th_ll} & req;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      smp_ll     <= '0;
      smp_ps     <= '0;
      smp_ne     <= '0;
      vote_valid <= 1'b0;
      vote_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (!en || complete) pend_q <= '0;
      else                 pend_q <= pend_q | strb;
      if (strb[0]) smp_ll <= din_ll;
      if (strb[1]) smp_ps <= din_ps;
      if (strb[2]) smp_ne <= din_ne;
      vote_valid <= complete;
      if (complete)
        vote_count <= {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
      if (|(strb & pend_q)) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  logic                 positive;
  state_t               st_q, st_nxt;
  logic [CNT_WIDTH-1:0] hits_q, hits_nxt, cnt_q, cnt_nxt;

  assign positive = vote_valid && (vote_count >= VOTE_MIN_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      hits_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_nxt;
      hits_q <= hits_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise the paths that do
  // not assign it would infer a latch.
  always_comb begin
    st_nxt   = st_q;
    hits_nxt = hits_q;
    cnt_nxt  = cnt_q;
    if (!en) begin
      st_nxt   = IDLE;
      hits_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (positive) begin
            hits_nxt = CNT_WIDTH'(1);
            cnt_nxt  = '0;
            st_nxt   = (HOLD_V == CNT_WIDTH'(1)) ? STIM : ARMED;
          end
        end
        ARMED: begin
          if (positive) begin
            hits_nxt = hits_q + 1'b1;
            cnt_nxt  = '0;
            if (hits_q + 1'b1 == HOLD_V) st_nxt = STIM;
          end else if (vote_valid) begin
            hits_nxt = '0;
            st_nxt   = IDLE;
          end
        end
        STIM: begin
          if (cnt_q == STIM_LAST) begin
            cnt_nxt  = '0;
            hits_nxt = '0;
            st_nxt   = (REFRACT_LEN == 0) ? IDLE : REFRACT;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        REFRACT: begin
          if (cnt_q == REFR_LAST) begin
            cnt_nxt  = '0;
            hits_nxt = '0;
            st_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so an async reset drops the drive at once.
  always_comb begin
    stimulation = (st_q == STIM);
    state       = st_q;
  end

endmodule

// File: tb/tb_stim_vote_ctrl.sv
// Directed-vector bench for stim_vote_ctrl in its default configuration (no feature mask).
module tb_stim_vote_ctrl;

  logic               clk = 1'b0;
  logic               rst, en, clr_overrun;
  logic signed [24:0] din_ll, th_ll;
  logic signed [39:0] din_ps, din_ne, th_ps, th_ne;
  logic               data_ready_ll, data_ready_ps, data_ready_ne;
  logic               vote_valid, stimulation, overrun;
  logic [1:0]         vote_count, state;

  int n_vec = 0;
  int n_err = 0;

  stim_vote_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .din_ll        (din_ll),
    .din_ps        (din_ps),
    .din_ne        (din_ne),
    .data_ready_ll (data_ready_ll),
    .data_ready_ps (data_ready_ps),
    .data_ready_ne (data_ready_ne),
    .th_ll         (th_ll),
    .th_ps         (th_ps),
    .th_ne         (th_ne),
    .clr_overrun   (clr_overrun),
    .vote_valid    (vote_valid),
    .vote_count    (vote_count),
    .stimulation   (stimulation),
    .state         (state),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en = 1'b1;
    clr_overrun = 1'b0;
    data_ready_ll = 1'b0;
    data_ready_ps = 1'b0;
    data_ready_ne = 1'b0;
    th_ll = 25'sd1000;
    th_ps = 40'sd1000;
    th_ne = 40'sd1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Strobes all three features for one cycle; returns in the cycle the vote is visible.
  task automatic send_set(input logic signed [24:0] ll, input logic signed [39:0] ps,
                          input logic signed [39:0] ne);
    din_ll = ll;
    din_ps = ps;
    din_ne = ne;
    data_ready_ll = 1'b1;
    data_ready_ps = 1'b1;
    data_ready_ne = 1'b1;
    step();
    data_ready_ll = 1'b0;
    data_ready_ps = 1'b0;
    data_ready_ne = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    clr_overrun = 1'b0;
    data_ready_ll = 1'b0;
    data_ready_ps = 1'b0;
    data_ready_ne = 1'b0;
    din_ll = '0; din_ps = '0; din_ne = '0;
    th_ll = 25'sd1000; th_ps = 40'sd1000; th_ne = 40'sd1000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({vote_valid, vote_count, stimulation, state, overrun} !== 7'd0) begin
      $display("FAIL reset_outputs: got %b expected 0000000",
               {vote_valid, vote_count, stimulation, state, overrun});
      n_err++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_vote();
    apply_reset();
    send_set(25'sd1500, 40'sd1500, 40'sd0);
    n_vec++;
    if (vote_valid !== 1'b1) begin
      $display("FAIL basic_valid: got %b expected 1", vote_valid); n_err++;
    end
    n_vec++;
    if (vote_count !== 2'd2) begin
      $display("FAIL basic_count: got %0d expected 2", vote_count); n_err++;
    end
    step();
    n_vec++;
    if (state !== 2'd1) begin
      $display("FAIL basic_armed: got %0d expected 1", state); n_err++;
    end
    n_vec++;
    if (vote_valid !== 1'b0) begin
      $display("FAIL basic_valid_pulse: got %b expected 0", vote_valid); n_err++;
    end
  endtask

  task automatic test_stim_refract();
    logic [1:0] exp_st;
    apply_reset();
    repeat (4) send_set(25'sd2000, 40'sd2000, 40'sd2000);
    n_vec++;
    if (state !== 2'd1 || stimulation !== 1'b0) begin
      $display("FAIL stim_decision: got state %0d stim %b expected state 1 stim 0",
               state, stimulation);
      n_err++;
    end
    for (int i = 0; i < 82; i++) begin
      step();
      exp_st = (i < 16) ? 2'd2 : ((i < 80) ? 2'd3 : 2'd0);
      n_vec++;
      if (state !== exp_st || stimulation !== (i < 16)) begin
        $display("FAIL stim_seq[%0d]: got state %0d stim %b expected state %0d stim %b",
                 i, state, stimulation, exp_st, (i < 16));
        n_err++;
      end
    end
  endtask

  task automatic test_abort_restart();
    apply_reset();
    repeat (3) send_set(25'sd2000, 40'sd2000, 40'sd2000);
    send_set(25'sd2000, 40'sd0, 40'sd0);
    n_vec++;
    if (vote_count !== 2'd1 || state !== 2'd1) begin
      $display("FAIL abort_vote: got count %0d state %0d expected count 1 state 1",
               vote_count, state);
      n_err++;
    end
    step();
    n_vec++;
    if (state !== 2'd0 || stimulation !== 1'b0) begin
      $display("FAIL abort_idle: got state %0d stim %b expected state 0 stim 0",
               state, stimulation);
      n_err++;
    end
    repeat (3) send_set(25'sd2000, 40'sd2000, 40'sd2000);
    step();
    n_vec++;
    if (state !== 2'd1) begin
      $display("FAIL restart_hits: got state %0d expected 1", state); n_err++;
    end
    send_set(25'sd2000, 40'sd2000, 40'sd2000);
    step();
    n_vec++;
    if (state !== 2'd2 || stimulation !== 1'b1) begin
      $display("FAIL restart_stim: got state %0d stim %b expected state 2 stim 1",
               state, stimulation);
      n_err++;
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    din_ll = 25'sd500;
    data_ready_ll = 1'b1;
    step();
    n_vec++;
    if (overrun !== 1'b0 || vote_valid !== 1'b0) begin
      $display("FAIL overrun_first: got ovr %b valid %b expected 0 0", overrun, vote_valid);
      n_err++;
    end
    din_ll = 25'sd1500;
    step();
    data_ready_ll = 1'b0;
    n_vec++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_set: got %b expected 1", overrun); n_err++;
    end
    din_ps = 40'sd1500;
    din_ne = 40'sd0;
    data_ready_ps = 1'b1;
    data_ready_ne = 1'b1;
    step();
    data_ready_ps = 1'b0;
    data_ready_ne = 1'b0;
    n_vec++;
    if (vote_valid !== 1'b1 || vote_count !== 2'd2) begin
      $display("FAIL overrun_latest: got valid %b count %0d expected valid 1 count 2",
               vote_valid, vote_count);
      n_err++;
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_clear: got %b expected 0", overrun); n_err++;
    end
  endtask

  task automatic test_signed_compare();
    apply_reset();
    th_ll = -25'sd16777216;
    th_ps = -40'sd2;
    th_ne = -40'sd2;
    send_set(25'sd16777215, -40'sd1, -40'sd3);
    n_vec++;
    if (vote_count !== 2'd2) begin
      $display("FAIL signed_mixed: got %0d expected 2", vote_count); n_err++;
    end
    send_set(-25'sd16777216, -40'sd2, -40'sd2);
    n_vec++;
    if (vote_count !== 2'd3) begin
      $display("FAIL signed_equal: got %0d expected 3", vote_count); n_err++;
    end
  endtask

  task automatic test_en_drop();
    apply_reset();
    repeat (2) send_set(25'sd2000, 40'sd2000, 40'sd2000);
    din_ll = 25'sd2000;
    data_ready_ll = 1'b1;
    step();
    data_ready_ll = 1'b0;
    n_vec++;
    if (state !== 2'd1) begin
      $display("FAIL en_armed: got state %0d expected 1", state); n_err++;
    end
    en = 1'b0;
    step();
    n_vec++;
    if (state !== 2'd0 || stimulation !== 1'b0) begin
      $display("FAIL en_idle: got state %0d stim %b expected state 0 stim 0",
               state, stimulation);
      n_err++;
    end
    en = 1'b1;
    din_ps = 40'sd2000;
    din_ne = 40'sd2000;
    data_ready_ps = 1'b1;
    data_ready_ne = 1'b1;
    step();
    data_ready_ps = 1'b0;
    data_ready_ne = 1'b0;
    n_vec++;
    if (vote_valid !== 1'b0) begin
      $display("FAIL en_discard: got valid %b expected 0", vote_valid); n_err++;
    end
    data_ready_ll = 1'b1;
    step();
    data_ready_ll = 1'b0;
    n_vec++;
    if (vote_valid !== 1'b1 || vote_count !== 2'd3) begin
      $display("FAIL en_fresh_set: got valid %b count %0d expected valid 1 count 3",
               vote_valid, vote_count);
      n_err++;
    end
  endtask

  task automatic test_rst_mid_stim();
    apply_reset();
    repeat (4) send_set(25'sd2000, 40'sd2000, 40'sd2000);
    repeat (3) step();
    n_vec++;
    if (stimulation !== 1'b1) begin
      $display("FAIL rst_pre_stim: got %b expected 1", stimulation); n_err++;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (stimulation !== 1'b0 || state !== 2'd0) begin
      $display("FAIL rst_async_drop: got stim %b state %0d expected stim 0 state 0",
               stimulation, state);
      n_err++;
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_stim_refract();
    test_abort_restart();
    test_overrun();
    test_signed_compare();
    test_en_drop();
    test_rst_mid_stim();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
